// File: rtl/audio_rom_arbiter.sv
// Arbitrates the serial-flash read sequencer between round-robin voice requesters
// and an exclusive CPU owner, with inter-transaction gap timing and a busy watchdog.
module audio_rom_arbiter #(
  parameter int pVoiceNum     = 4,
  parameter int pSfmPageWidth = 16
) (
  input  logic                               iSCLK,
  input  logic                               iSRST,
  input  logic [pVoiceNum-1:0]               iVoiceReq,
  input  logic [pVoiceNum*pSfmPageWidth-1:0] iVoiceStartAdrs,
  input  logic [pVoiceNum*pSfmPageWidth-1:0] iVoiceEndAdrs,
  output logic [pVoiceNum-1:0]               oVoiceGnt,
  output logic [pVoiceNum-1:0]               oVoiceDone,
  input  logic                               iCpuReq,
  input  logic                               iCpuRelease,
  output logic                               oCpuGnt,
  output logic                               oSfmEn,
  output logic [pSfmPageWidth-1:0]           oSfmStartAdrs,
  output logic [pSfmPageWidth-1:0]           oSfmEndAdrs,
  input  logic                               iSfmDone,
  input  logic [7:0]                         iGapCycles,
  input  logic [15:0]                        iTimeout,
  output logic                               oTimeoutErr
);

  localparam int IW = $clog2(pVoiceNum);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_BUSY, S_CPU, S_GAP} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [pVoiceNum-1:0]     gnt_q, gnt_d, done_q, done_d;
  logic                     cpu_gnt_q, cpu_gnt_d, en_q, en_d, err_q, err_d;
  logic [pSfmPageWidth-1:0] start_q, start_d, end_q, end_d;
  logic [15:0]              wdog_q, wdog_d, wdog_inc;
  logic [7:0]               gap_q, gap_d;
  logic                     gap_last;
  state_t                   post_state;

  logic                     win_vld;
  logic [IW-1:0]            win_idx;
  logic [IW:0]              cand;

  // Round-robin search begins one past the last granted voice.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= pVoiceNum; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(pVoiceNum)) cand = cand - (IW+1)'(pVoiceNum);
      if (!win_vld && iVoiceReq[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  assign wdog_inc   = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
  assign gap_last   = ({1'b0, gap_q} + 9'd1) >= {1'b0, iGapCycles};
  assign post_state = (iGapCycles == 8'd0) ? S_IDLE : S_GAP;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    cpu_gnt_d = cpu_gnt_q;
    en_d      = en_q;
    err_d     = 1'b0;
    start_d   = start_q;
    end_d     = end_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: if ((|iVoiceReq) || iCpuReq) state_d = S_ARB;
      S_ARB: begin
        if (iCpuReq) begin
          state_d   = S_CPU;
          cpu_gnt_d = 1'b1;
        end else if (win_vld) begin
          state_d = S_LOAD;
          ptr_d   = win_idx;
          gnt_d   = {{(pVoiceNum-1){1'b0}}, 1'b1} << win_idx;
          start_d = iVoiceStartAdrs[win_idx*pSfmPageWidth +: pSfmPageWidth];
          end_d   = iVoiceEndAdrs[win_idx*pSfmPageWidth +: pSfmPageWidth];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_BUSY;
        en_d    = 1'b1;
        wdog_d  = '0;
      end
      S_BUSY: begin
        wdog_d = wdog_inc;
        // Completion outranks a watchdog hit landing on the same cycle.
        if (iSfmDone) begin
          en_d    = 1'b0;
          gnt_d   = '0;
          done_d  = gnt_q;
          gap_d   = '0;
          state_d = post_state;
        end else if ((iTimeout != 16'd0) && (wdog_inc == iTimeout)) begin
          en_d    = 1'b0;
          gnt_d   = '0;
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = post_state;
        end
      end
      S_CPU: if (iCpuRelease) begin
        cpu_gnt_d = 1'b0;
        gap_d     = '0;
        state_d   = post_state;
      end
      S_GAP: begin
        if (gap_last) state_d = S_IDLE;
        else          gap_d   = gap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      cpu_gnt_q <= 1'b0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      cpu_gnt_q <= cpu_gnt_d;
      en_q      <= en_d;
      err_q     <= err_d;
      start_q   <= start_d;
      end_q     <= end_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
    end
  end

  assign oVoiceGnt     = gnt_q;
  assign oVoiceDone    = done_q;
  assign oCpuGnt       = cpu_gnt_q;
  assign oSfmEn        = en_q;
  assign oTimeoutErr   = err_q;
  assign oSfmStartAdrs = start_q;
  assign oSfmEndAdrs   = end_q;

endmodule

// File: tb/tb_audio_rom_arbiter.sv
// Scoreboard bench for audio_rom_arbiter: expected grants queued at stimulus time,
// popped and compared when the arbiter raises a grant.
module tb_audio_rom_arbiter;
  localparam int NV = 4;
  localparam int PW = 16;

  logic             iSCLK = 1'b0;
  logic             iSRST = 1'b1;
  logic [NV-1:0]    iVoiceReq = '0;
  logic [NV*PW-1:0] iVoiceStartAdrs = '0;
  logic [NV*PW-1:0] iVoiceEndAdrs = '0;
  logic [NV-1:0]    oVoiceGnt, oVoiceDone;
  logic             iCpuReq = 1'b0, iCpuRelease = 1'b0;
  logic             oCpuGnt, oSfmEn, oTimeoutErr;
  logic [PW-1:0]    oSfmStartAdrs, oSfmEndAdrs;
  logic             iSfmDone = 1'b0;
  logic [7:0]       iGapCycles = '0;
  logic [15:0]      iTimeout = '0;

  always #5 iSCLK = ~iSCLK;

  audio_rom_arbiter #(.pVoiceNum(NV), .pSfmPageWidth(PW)) dut (
    .iSCLK(iSCLK), .iSRST(iSRST), .iVoiceReq(iVoiceReq),
    .iVoiceStartAdrs(iVoiceStartAdrs), .iVoiceEndAdrs(iVoiceEndAdrs),
    .oVoiceGnt(oVoiceGnt), .oVoiceDone(oVoiceDone), .iCpuReq(iCpuReq),
    .iCpuRelease(iCpuRelease), .oCpuGnt(oCpuGnt), .oSfmEn(oSfmEn),
    .oSfmStartAdrs(oSfmStartAdrs), .oSfmEndAdrs(oSfmEndAdrs), .iSfmDone(iSfmDone),
    .iGapCycles(iGapCycles), .iTimeout(iTimeout), .oTimeoutErr(oTimeoutErr)
  );

  typedef struct {int idx; logic [PW-1:0] s; logic [PW-1:0] e;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic [PW-1:0] st_tab[NV], en_tab[NV];

  task automatic tick(); @(posedge iSCLK); #1; endtask

  task automatic drive_addrs();
    for (int k = 0; k < NV; k++) begin
      iVoiceStartAdrs[k*PW +: PW] = st_tab[k];
      iVoiceEndAdrs[k*PW +: PW]   = en_tab[k];
    end
  endtask

  task automatic push_exp(input int k);
    exp_t x;
    x.idx = k; x.s = st_tab[k]; x.e = en_tab[k];
    exp_q.push_back(x);
  endtask

  task automatic wait_gnt(input int limit, output int cyc);
    cyc = 0;
    while (oVoiceGnt == '0 && cyc < limit) begin tick(); cyc++; end
  endtask

  task automatic do_reset();
    iSRST = 1'b1; iVoiceReq = '0; iCpuReq = 1'b0; iCpuRelease = 1'b0; iSfmDone = 1'b0;
    exp_q.delete();
    tick(); tick();
    iSRST = 1'b0;
  endtask

  task automatic test_reset();
    iSRST = 1'b1; iVoiceReq = '1; iCpuReq = 1'b1;
    tick(); tick();
    n_chk++;
    if ({oVoiceGnt, oVoiceDone, oCpuGnt, oSfmEn, oTimeoutErr} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b done=%b cpu=%b en=%b err=%b, want all 0",
               oVoiceGnt, oVoiceDone, oCpuGnt, oSfmEn, oTimeoutErr);
    end
    n_chk++;
    if (oSfmStartAdrs !== '0 || oSfmEndAdrs !== '0) begin
      n_fail++; $display("FAIL reset_adrs: start=%h end=%h, want 0", oSfmStartAdrs, oSfmEndAdrs);
    end
    iVoiceReq = '0; iCpuReq = 1'b0; tick();
    iSRST = 1'b0; tick(); tick();
    n_chk++;
    if (oVoiceGnt !== '0 || oCpuGnt !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: gnt=%b cpu=%b, want 0", oVoiceGnt, oCpuGnt);
    end
  endtask

  task automatic test_single();
    int cyc; exp_t x;
    do_reset();
    iGapCycles = 8'd2;
    st_tab[2] = 16'h0010; en_tab[2] = 16'h0020; drive_addrs();
    iVoiceReq = 4'b0100; push_exp(2);
    wait_gnt(10, cyc);
    n_chk++;
    if (cyc != 2) begin n_fail++; $display("FAIL load_latency: got %0d cycles, want 2", cyc); end
    x = exp_q.pop_front();
    n_chk++;
    if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmStartAdrs !== x.s || oSfmEndAdrs !== x.e || oSfmEn !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b start=%h end=%h en=%b, want gnt=%b start=%h end=%h en=0",
               oVoiceGnt, oSfmStartAdrs, oSfmEndAdrs, oSfmEn, NV'(1) << x.idx, x.s, x.e);
    end
    // request drops and address inputs change while the transaction is in flight
    iVoiceReq = '0; st_tab[2] = 16'hBEEF; en_tab[2] = 16'hCAFE; drive_addrs();
    tick();
    n_chk++;
    if (oSfmEn !== 1'b1) begin n_fail++; $display("FAIL busy_en: got %b, want 1", oSfmEn); end
    tick(); tick();
    n_chk++;
    if (oSfmStartAdrs !== x.s || oSfmEndAdrs !== x.e || oVoiceGnt !== 4'b0100) begin
      n_fail++; $display("FAIL adrs_stable: start=%h end=%h gnt=%b, want %h %h 0100",
                         oSfmStartAdrs, oSfmEndAdrs, oVoiceGnt, x.s, x.e);
    end
    iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
    n_chk++;
    if (oVoiceDone !== 4'b0100 || oSfmEn !== 1'b0 || oVoiceGnt !== '0) begin
      n_fail++; $display("FAIL done_pulse: done=%b en=%b gnt=%b, want 0100 0 0000", oVoiceDone, oSfmEn, oVoiceGnt);
    end
    tick();
    n_chk++;
    if (oVoiceDone !== '0) begin n_fail++; $display("FAIL done_one_cycle: got %b, want 0000", oVoiceDone); end
    iSfmDone = 1'b1; tick(); iSfmDone = 1'b0; iCpuRelease = 1'b1; tick(); iCpuRelease = 1'b0; tick();
    n_chk++;
    if (oVoiceDone !== '0 || oCpuGnt !== 1'b0 || oSfmEn !== 1'b0 || oVoiceGnt !== '0) begin
      n_fail++; $display("FAIL stray_pulses: done=%b cpu=%b en=%b gnt=%b, want all 0",
                         oVoiceDone, oCpuGnt, oSfmEn, oVoiceGnt);
    end
  endtask

  task automatic test_round_robin();
    int cyc, p; exp_t x;
    do_reset();
    iGapCycles = 8'd3;
    for (int k = 0; k < NV; k++) begin
      st_tab[k] = PW'(16'h1000 * k + 16'h0011);
      en_tab[k] = PW'(16'h1000 * k + 16'h0EE0);
    end
    drive_addrs();
    p = 0;
    for (int t = 0; t < 5; t++) begin p = (p + 1) % NV; push_exp(p); end
    iVoiceReq = '1;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(20, cyc);
      n_chk++;
      if (cyc != ((t == 0) ? 2 : 3 + 2)) begin
        n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles, want %0d", t, cyc, (t == 0) ? 2 : 5);
      end
      x = exp_q.pop_front();
      n_chk++;
      if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmStartAdrs !== x.s || oSfmEndAdrs !== x.e) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b start=%h end=%h, want gnt=%b start=%h end=%h",
                 t, oVoiceGnt, oSfmStartAdrs, oSfmEndAdrs, NV'(1) << x.idx, x.s, x.e);
      end
      if (t == 4) iVoiceReq = '0;
      tick(); tick();
      iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
      n_chk++;
      if (oVoiceDone !== (NV'(1) << x.idx) || oSfmEn !== 1'b0) begin
        n_fail++; $display("FAIL rr_done[%0d]: done=%b en=%b, want %b 0", t, oVoiceDone, oSfmEn, NV'(1) << x.idx);
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_cpu_priority();
    int cyc; exp_t x;
    do_reset();
    iGapCycles = 8'd1;
    st_tab[0] = 16'h0A00; en_tab[0] = 16'h0AFF; drive_addrs();
    iCpuReq = 1'b1; iVoiceReq = 4'b0001; push_exp(0);
    tick(); tick();
    n_chk++;
    if (oCpuGnt !== 1'b1 || oVoiceGnt !== '0 || oSfmEn !== 1'b0) begin
      n_fail++; $display("FAIL cpu_wins: cpu=%b gnt=%b en=%b, want 1 0000 0", oCpuGnt, oVoiceGnt, oSfmEn);
    end
    tick(); iSfmDone = 1'b1; tick(); iSfmDone = 1'b0; tick();
    n_chk++;
    if (oCpuGnt !== 1'b1 || oSfmEn !== 1'b0 || oVoiceDone !== '0) begin
      n_fail++; $display("FAIL cpu_hold: cpu=%b en=%b done=%b, want 1 0 0000", oCpuGnt, oSfmEn, oVoiceDone);
    end
    iCpuReq = 1'b0; iCpuRelease = 1'b1; tick(); iCpuRelease = 1'b0;
    n_chk++;
    if (oCpuGnt !== 1'b0) begin n_fail++; $display("FAIL cpu_release: got %b, want 0", oCpuGnt); end
    wait_gnt(10, cyc);
    n_chk++;
    if (cyc != 3) begin n_fail++; $display("FAIL cpu_to_voice: got %0d cycles, want 3", cyc); end
    x = exp_q.pop_front();
    n_chk++;
    if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmStartAdrs !== x.s || oSfmEndAdrs !== x.e) begin
      n_fail++; $display("FAIL cpu_voice_grant: gnt=%b start=%h end=%h, want %b %h %h",
                         oVoiceGnt, oSfmStartAdrs, oSfmEndAdrs, NV'(1) << x.idx, x.s, x.e);
    end
    iVoiceReq = '0; tick(); tick();
    iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
    n_chk++;
    if (oVoiceDone !== 4'b0001) begin n_fail++; $display("FAIL cpu_voice_done: got %b, want 0001", oVoiceDone); end
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    int cyc, n; bit seen; exp_t x;
    do_reset();
    iGapCycles = 8'd1; iTimeout = 16'd100;
    st_tab[3] = 16'h3300; en_tab[3] = 16'h33FF; drive_addrs();
    // case A: sequencer never answers
    iVoiceReq = 4'b1000; push_exp(3);
    wait_gnt(10, cyc);
    x = exp_q.pop_front();
    n_chk++;
    if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmStartAdrs !== x.s) begin
      n_fail++; $display("FAIL to_grant: gnt=%b start=%h, want %b %h", oVoiceGnt, oSfmStartAdrs, NV'(1) << x.idx, x.s);
    end
    iVoiceReq = '0; tick();
    n = 0; seen = 1'b0;
    while (!oTimeoutErr && n < 300) begin tick(); n++; if (oVoiceDone != '0) seen = 1'b1; end
    n_chk++;
    if (n != 100 || oSfmEn !== 1'b0 || oVoiceGnt !== '0 || seen) begin
      n_fail++; $display("FAIL timeout_abort: cycles=%0d en=%b gnt=%b done_seen=%0d, want 100 0 0000 0",
                         n, oSfmEn, oVoiceGnt, seen);
    end
    tick();
    n_chk++;
    if (oTimeoutErr !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b, want 0", oTimeoutErr); end
    repeat (3) tick();
    // case B: done lands on the very cycle the watchdog would fire
    iVoiceReq = 4'b1000; push_exp(3);
    wait_gnt(10, cyc);
    x = exp_q.pop_front();
    n_chk++;
    if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmEndAdrs !== x.e) begin
      n_fail++; $display("FAIL to2_grant: gnt=%b end=%h, want %b %h", oVoiceGnt, oSfmEndAdrs, NV'(1) << x.idx, x.e);
    end
    iVoiceReq = '0; tick();
    repeat (99) tick();
    n_chk++;
    if (oSfmEn !== 1'b1 || oTimeoutErr !== 1'b0) begin
      n_fail++; $display("FAIL no_early_abort: en=%b err=%b, want 1 0", oSfmEn, oTimeoutErr);
    end
    iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
    n_chk++;
    if (oVoiceDone !== 4'b1000 || oTimeoutErr !== 1'b0) begin
      n_fail++; $display("FAIL done_wins: done=%b err=%b, want 1000 0", oVoiceDone, oTimeoutErr);
    end
    repeat (3) tick();
    // case C: watchdog disabled
    iTimeout = 16'd0;
    iVoiceReq = 4'b1000; push_exp(3);
    wait_gnt(10, cyc);
    x = exp_q.pop_front();
    iVoiceReq = '0; seen = 1'b0;
    repeat (150) begin tick(); if (oTimeoutErr) seen = 1'b1; end
    n_chk++;
    if (seen || oSfmEn !== 1'b1 || oVoiceGnt !== (NV'(1) << x.idx)) begin
      n_fail++; $display("FAIL wdog_disabled: err_seen=%0d en=%b gnt=%b, want 0 1 %b", seen, oSfmEn, oVoiceGnt, NV'(1) << x.idx);
    end
    iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_busy();
    int cyc; exp_t x;
    do_reset();
    iGapCycles = 8'd0; iTimeout = 16'd0;
    for (int k = 0; k < NV; k++) begin
      st_tab[k] = PW'(16'h0200 + k); en_tab[k] = PW'(16'h0300 + k);
    end
    drive_addrs();
    iVoiceReq = '1; push_exp(1);
    wait_gnt(10, cyc);
    x = exp_q.pop_front();
    tick(); tick();
    n_chk++;
    if (oSfmEn !== 1'b1 || oVoiceGnt !== (NV'(1) << x.idx)) begin
      n_fail++; $display("FAIL pre_reset_busy: en=%b gnt=%b, want 1 %b", oSfmEn, oVoiceGnt, NV'(1) << x.idx);
    end
    iSRST = 1'b1; tick();
    n_chk++;
    if ({oVoiceGnt, oVoiceDone, oCpuGnt, oSfmEn, oTimeoutErr} !== '0 || oSfmStartAdrs !== '0 || oSfmEndAdrs !== '0) begin
      n_fail++; $display("FAIL mid_busy_reset: gnt=%b done=%b cpu=%b en=%b err=%b start=%h end=%h, want all 0",
                         oVoiceGnt, oVoiceDone, oCpuGnt, oSfmEn, oTimeoutErr, oSfmStartAdrs, oSfmEndAdrs);
    end
    tick();
    iSRST = 1'b0; push_exp(1);
    wait_gnt(10, cyc);
    x = exp_q.pop_front();
    n_chk++;
    if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmStartAdrs !== x.s || oSfmEndAdrs !== x.e) begin
      n_fail++; $display("FAIL first_after_reset: gnt=%b start=%h end=%h, want %b %h %h",
                         oVoiceGnt, oSfmStartAdrs, oSfmEndAdrs, NV'(1) << x.idx, x.s, x.e);
    end
    tick(); iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
    push_exp(2);
    wait_gnt(10, cyc);
    n_chk++;
    if (cyc != 2) begin n_fail++; $display("FAIL zero_gap: got %0d cycles, want 2", cyc); end
    x = exp_q.pop_front();
    n_chk++;
    if (oVoiceGnt !== (NV'(1) << x.idx) || oSfmStartAdrs !== x.s) begin
      n_fail++; $display("FAIL zero_gap_grant: gnt=%b start=%h, want %b %h", oVoiceGnt, oSfmStartAdrs, NV'(1) << x.idx, x.s);
    end
    iVoiceReq = '0; tick(); iSfmDone = 1'b1; tick(); iSfmDone = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    for (int k = 0; k < NV; k++) begin st_tab[k] = '0; en_tab[k] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_cpu_priority();
    test_timeout();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
